// File: rtl/ov7670_pkg.sv
// Shared types and constants for the synthetic OV7670 pixel source.
// Holds the FSM state enum, pattern selectors, RGB444 pixel type and default timing.
package ov7670_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_e;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_SOLID = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_H_GAP       = 288;
  localparam int DEF_VSYNC_LINES = 3;
  localparam int DEF_V_BACK      = 17;
  localparam int DEF_V_FRONT     = 10;

  // xR/GB byte order: first byte carries R, second carries G and B.
  function automatic logic [7:0] rgb_byte(
    input rgb444_t p,
    input logic    second
  );
    return second ? {p.g, p.b} : {4'h0, p.r};
  endfunction

endpackage

// File: rtl/ov7670_pattern_gen.sv
// Pixel-value generator for the stream source; counters advance on strobes.
// Ports: clk/rst, frame/line/pixel-advance strobes, latched sel + solid colour, pixel out.
module ov7670_pattern_gen
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_stb,
  input  logic       line_stb,
  input  logic       adv_stb,
  input  logic [1:0] sel,
  input  rgb444_t    solid,
  output rgb444_t    pixel
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BCW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BCW-1:0] BAR_LAST = BCW'(BAR_W - 1);

  logic [BCW-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]     bar_q, bar_d;
  logic [11:0]    ramp_q, ramp_d;
  // Only bit 5 of x and y matters for the checker, so 6 bits suffice.
  logic [5:0]     x_q, x_d;
  logic [5:0]     y_q, y_d;

  always_comb begin
    bar_cnt_d = bar_cnt_q;
    bar_d     = bar_q;
    ramp_d    = ramp_q;
    x_d       = x_q;
    y_d       = y_q;
    if (frame_stb) begin
      bar_cnt_d = '0;
      bar_d     = '0;
      ramp_d    = '0;
      x_d       = '0;
      y_d       = '0;
    end else begin
      if (adv_stb) begin
        ramp_d = ramp_q + 12'd1;
        x_d    = x_q + 6'd1;
        if (bar_cnt_q == BAR_LAST) begin
          bar_cnt_d = '0;
          bar_d     = bar_q + 3'd1;
        end else begin
          bar_cnt_d = bar_cnt_q + BCW'(1);
        end
      end
      if (line_stb) begin
        bar_cnt_d = '0;
        bar_d     = '0;
        x_d       = '0;
        y_d       = y_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_cnt_q <= '0;
      bar_q     <= '0;
      ramp_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      bar_cnt_q <= bar_cnt_d;
      bar_q     <= bar_d;
      ramp_q    <= ramp_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  always_comb begin
    pixel = '0;
    unique case (1'b1)
      (sel == PAT_BARS):  pixel = {{4{bar_q[2]}}, {4{bar_q[1]}}, {4{bar_q[0]}}};
      (sel == PAT_RAMP):  pixel = ramp_q;
      (sel == PAT_SOLID): pixel = solid;
      (sel == PAT_CHECK): pixel = (x_q[5] ^ y_q[5]) ? 12'hFFF : 12'h000;
      default:            pixel = '0;
    endcase
  end

endmodule

// File: rtl/ov7670_stream_tx.sv
// Synthetic OV7670 camera source: VSYNC/HREF timing and RGB444 byte stream.
// Ports: clk (=PCLK), rst, enable, pattern_sel, solid_rgb -> vsync, href, d, frame strobes, count.
module ov7670_stream_tx
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int H_GAP       = DEF_H_GAP,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int V_FRONT     = DEF_V_FRONT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] solid_rgb,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        frame_start,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_GAP;
  localparam int HW       = $clog2(LINE_LEN);
  localparam int VM1      = (V_ACTIVE > VSYNC_LINES) ? V_ACTIVE : VSYNC_LINES;
  localparam int VM2      = (V_BACK > V_FRONT) ? V_BACK : V_FRONT;
  localparam int VMAX     = (VM1 > VM2) ? VM1 : VM2;
  localparam int VW       = $clog2(VMAX + 1);

  localparam logic [HW-1:0] HC_LAST  = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0] HC_ACT   = HW'(2 * H_ACTIVE);
  localparam logic [HW-1:0] HC_LBYTE = HW'(2 * H_ACTIVE - 1);
  localparam logic [VW-1:0] VS_LAST  = VW'(VSYNC_LINES - 1);
  localparam logic [VW-1:0] VB_LAST  = VW'(V_BACK - 1);
  localparam logic [VW-1:0] VA_LAST  = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VF_LAST  = VW'(V_FRONT - 1);

  state_e         state_q, state_d;
  logic [HW-1:0]  hc_q, hc_d;
  logic [VW-1:0]  vc_q, vc_d;
  logic           vsync_q, vsync_d;
  logic           href_q, href_d;
  logic [7:0]     d_q, d_d;
  logic           frame_start_q, frame_start_d;
  logic           frame_done_q, frame_done_d;
  logic [15:0]    frame_count_q, frame_count_d;
  logic [1:0]     sel_q, sel_d;
  rgb444_t        solid_q, solid_d;

  logic           line_end;
  logic           phase_last;
  logic           adv_stb;
  logic           line_stb;
  rgb444_t        pixel;

  // state/hc/vc describe what the ports show now; every output is
  // registered from the next position so all ports move on one edge.
  always_comb begin
    state_d  = state_q;
    hc_d     = hc_q;
    vc_d     = vc_q;
    line_end = (hc_q == HC_LAST);

    phase_last = 1'b0;
    unique case (state_q)
      ST_VSYNC:  phase_last = (vc_q == VS_LAST);
      ST_VBACK:  phase_last = (vc_q == VB_LAST);
      ST_ACTIVE: phase_last = (vc_q == VA_LAST);
      ST_VFRONT: phase_last = (vc_q == VF_LAST);
      default:   phase_last = 1'b0;
    endcase

    if (state_q == ST_IDLE) begin
      hc_d = '0;
      vc_d = '0;
      if (enable) state_d = ST_VSYNC;
    end else begin
      hc_d = line_end ? '0 : hc_q + HW'(1);
      if (line_end) begin
        if (phase_last) begin
          vc_d = '0;
          unique case (state_q)
            ST_VSYNC:  state_d = ST_VBACK;
            ST_VBACK:  state_d = ST_ACTIVE;
            ST_ACTIVE: state_d = ST_VFRONT;
            ST_VFRONT: state_d = enable ? ST_VSYNC : ST_IDLE;
            default:   state_d = ST_IDLE;
          endcase
        end else begin
          vc_d = vc_q + VW'(1);
        end
      end
    end

    vsync_d       = (state_d == ST_VSYNC);
    href_d        = (state_d == ST_ACTIVE) && (hc_d < HC_ACT);
    frame_start_d = (state_d == ST_VSYNC) && (state_q != ST_VSYNC);
    frame_done_d  = (state_d == ST_VFRONT) && (vc_d == VF_LAST) &&
                    (hc_d == HC_LAST);
    frame_count_d = frame_count_q + 16'(frame_done_d);

    adv_stb  = href_d && hc_d[0];
    line_stb = href_d && (hc_d == HC_LBYTE);
    d_d      = href_d ? rgb_byte(pixel, hc_d[0]) : 8'h00;

    sel_d   = frame_start_d ? pattern_sel : sel_q;
    solid_d = frame_start_d ? rgb444_t'(solid_rgb) : solid_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      hc_q          <= '0;
      vc_q          <= '0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      d_q           <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      sel_q         <= '0;
      solid_q       <= '0;
    end else begin
      state_q       <= state_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      vsync_q       <= vsync_d;
      href_q        <= href_d;
      d_q           <= d_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      sel_q         <= sel_d;
      solid_q       <= solid_d;
    end
  end

  // Strobes come from the next position, so the generator's pixel is
  // always the one being registered into d this cycle.
  ov7670_pattern_gen #(
    .H_ACTIVE(H_ACTIVE)
  ) u_pat (
    .clk      (clk),
    .rst      (rst),
    .frame_stb(frame_start_d),
    .line_stb (line_stb),
    .adv_stb  (adv_stb),
    .sel      (sel_q),
    .solid    (solid_q),
    .pixel    (pixel)
  );

  assign vsync       = vsync_q;
  assign href        = href_q;
  assign d           = d_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_ov7670_stream_tx.sv
// Scoreboard bench for ov7670_stream_tx with small frame timing.
// Expected bytes and frame counts are queued by stimulus and popped by a monitor.
module tb_ov7670_stream_tx;

  localparam int HA = 8;
  localparam int VA = 4;
  localparam int HG = 4;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int VF = 1;
  localparam int NREC = 500;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [11:0] solid_rgb = 12'h000;
  logic        vsync, href, frame_start, frame_done;
  logic [7:0]  d;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  ov7670_stream_tx #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_GAP(HG),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .vsync(vsync), .href(href), .d(d),
    .frame_start(frame_start), .frame_done(frame_done),
    .frame_count(frame_count)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0]  exp_bytes[$];
  logic [15:0] exp_fc[$];

  logic        vs_a[NREC];
  logic        hr_a[NREC];
  logic        fs_a[NREC];
  logic        fd_a[NREC];
  logic [7:0]  d_a[NREC];
  logic [15:0] fc_a[NREC];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] model_pix(input int pat,
      input logic [11:0] s, input int x, input int y);
    logic [2:0] b;
    int r;
    b = 3'(x / (HA / 8));
    case (pat)
      0: return {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
      1: begin
        r = (y * HA + x) % 4096;
        return 12'(r);
      end
      2: return s;
      default: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  task automatic push_frame(input int pat, input logic [11:0] s);
    logic [11:0] p;
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < HA; x++) begin
        p = model_pix(pat, s, x, y);
        exp_bytes.push_back({4'h0, p[11:8]});
        exp_bytes.push_back(p[7:0]);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a byte or a frame_done.
  always @(negedge clk) begin
    logic [7:0]  eb;
    logic [15:0] ef;
    if (!rst) begin
      if (href) begin
        if (exp_bytes.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_byte: got %0h with empty queue at %0t", d, $time);
        end else begin
          eb = exp_bytes.pop_front();
          chk("byte", {24'h0, d}, {24'h0, eb});
        end
      end else begin
        chk("d_zero_no_href", {24'h0, d}, 32'h0);
      end
      if (frame_done) begin
        if (exp_fc.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_done: count %0h with empty queue at %0t",
                   frame_count, $time);
        end else begin
          ef = exp_fc.pop_front();
          chk("frame_count_at_done", {16'h0, frame_count}, {16'h0, ef});
        end
      end
    end
  end

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (frame_done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(nm, {31'h0, (k < 200)}, 32'h1);
  endtask

  initial begin
    int cnt, first, last, bad, nz, k;
    int rise[$];

    repeat (3) @(negedge clk);
    chk("rst_vsync", {31'h0, vsync}, 32'h0);
    chk("rst_href", {31'h0, href}, 32'h0);
    chk("rst_d", {24'h0, d}, 32'h0);
    chk("rst_fstart", {31'h0, frame_start}, 32'h0);
    chk("rst_fdone", {31'h0, frame_done}, 32'h0);
    chk("rst_fcount", {16'h0, frame_count}, 32'h0);

    pattern_sel = 2'd1;
    enable = 1'b1;
    push_frame(1, 12'h000);
    exp_fc.push_back(16'd1);
    @(negedge clk);
    rst = 1'b0;
    chk("vsync_at_release", {31'h0, vsync}, 32'h0);

    for (int i = 0; i < NREC; i++) begin
      @(negedge clk);
      vs_a[i] = vsync;
      hr_a[i] = href;
      fs_a[i] = frame_start;
      fd_a[i] = frame_done;
      d_a[i]  = d;
      fc_a[i] = frame_count;
      if (i == 10) begin
        pattern_sel = 2'd0;
        push_frame(0, 12'h000);
        exp_fc.push_back(16'd2);
      end
      if (i == 170) begin
        pattern_sel = 2'd2;
        solid_rgb = 12'hABC;
        push_frame(2, 12'hABC);
        exp_fc.push_back(16'd3);
      end
      if (i == 385) begin
        pattern_sel = 2'd3;
        enable = 1'b0;
      end
    end

    cnt = 0; first = -1; last = -1;
    for (int i = 0; i < 160; i++) begin
      if (vs_a[i]) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("vsync_len", cnt, 40);
    chk("vsync_first", first, 0);
    chk("vsync_last", last, 39);

    bad = 0;
    for (int i = 1; i < 160; i++) begin
      if (hr_a[i] && !hr_a[i-1]) rise.push_back(i);
      if (hr_a[i] !== (i >= 60 && i < 140 && ((i - 60) % 20) < 16)) bad++;
    end
    chk("href_pulses", rise.size(), 4);
    chk("href_first_rise", (rise.size() > 0) ? rise[0] : -1, 60);
    chk("href_shape", bad, 0);

    chk("fstart_f1", {31'h0, fs_a[0]}, 32'h1);
    chk("fstart_f2", {31'h0, fs_a[160]}, 32'h1);
    chk("fstart_f3", {31'h0, fs_a[320]}, 32'h1);
    chk("fdone_f1", {31'h0, fd_a[159]}, 32'h1);
    chk("fdone_f3", {31'h0, fd_a[479]}, 32'h1);
    cnt = 0; k = 0;
    for (int i = 0; i < NREC; i++) begin
      if (fs_a[i]) cnt++;
      if (fd_a[i]) k++;
    end
    chk("fstart_total", cnt, 3);
    chk("fdone_total", k, 3);
    chk("fcount_before_done", {16'h0, fc_a[158]}, 32'h0);
    chk("fcount_at_done", {16'h0, fc_a[159]}, 32'h1);
    chk("fcount_idle", {16'h0, fc_a[NREC-1]}, 32'h3);

    chk("ramp_l1p2_b0", {24'h0, d_a[84]}, 32'h00);
    chk("ramp_l1p2_b1", {24'h0, d_a[85]}, 32'h0A);
    chk("ramp_last_b0", {24'h0, d_a[134]}, 32'h00);
    chk("ramp_last_b1", {24'h0, d_a[135]}, 32'h1F);
    chk("bars_p5_b0", {24'h0, d_a[230]}, 32'h0F);
    chk("bars_p5_b1", {24'h0, d_a[231]}, 32'h0F);
    chk("bars_p2_b0", {24'h0, d_a[224]}, 32'h00);
    chk("bars_p2_b1", {24'h0, d_a[225]}, 32'hF0);
    chk("solid_held_b0", {24'h0, d_a[420]}, 32'h0A);
    chk("solid_held_b1", {24'h0, d_a[421]}, 32'hBC);
    chk("solid_last_b1", {24'h0, d_a[455]}, 32'hBC);

    nz = 0;
    for (int i = 480; i < NREC; i++)
      if (vs_a[i] || hr_a[i] || fs_a[i] || fd_a[i] || d_a[i] != 8'h00) nz++;
    chk("idle_outputs_zero", nz, 0);

    enable = 1'b1;
    pattern_sel = 2'd1;
    push_frame(1, 12'h000);
    k = 0;
    while (href !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("href_before_reset", {31'h0, (k < 300)}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_href", {31'h0, href}, 32'h0);
    chk("arst_vsync", {31'h0, vsync}, 32'h0);
    chk("arst_d", {24'h0, d}, 32'h0);
    chk("arst_fcount", {16'h0, frame_count}, 32'h0);
    exp_bytes.delete();
    push_frame(1, 12'h000);
    exp_fc.push_back(16'd1);
    push_frame(1, 12'h000);
    exp_fc.push_back(16'h0000);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rel_vsync_low", {31'h0, vsync}, 32'h0);
    @(negedge clk);
    chk("restart_vsync", {31'h0, vsync}, 32'h1);
    chk("restart_fstart", {31'h0, frame_start}, 32'h1);
    wait_done("done_after_reset");

    repeat (10) @(negedge clk);
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_q;
    chk("fcount_forced", {16'h0, frame_count}, 32'hFFFF);
    enable = 1'b0;
    @(negedge clk);
    wait_done("done_wrap");
    repeat (5) @(negedge clk);
    chk("wrap_fcount", {16'h0, frame_count}, 32'h0);
    chk("final_idle_vsync", {31'h0, vsync}, 32'h0);
    chk("final_idle_href", {31'h0, href}, 32'h0);
    chk("bytes_left", exp_bytes.size(), 0);
    chk("counts_left", exp_fc.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
